// File: rtl/instr_sequencer.sv
// Three-state control sequencer (IDLE/DECODE/EXEC) for a reduced RV32I subset.
// Decodes ADDI/ADD/SUB/BNE into datapath controls and tracks PC and retire count.
module instr_sequencer #(
  parameter int                    Address_Width = 5,
  parameter int                    Data_Width    = 32,
  parameter logic [Data_Width-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  input  logic [Data_Width-1:0]    instr,
  output logic                     instr_ready,
  input  logic                     eq,
  output logic [Address_Width-1:0] rs1,
  output logic [Address_Width-1:0] rs2,
  output logic [Address_Width-1:0] rd,
  output logic                     en,
  output logic                     ALUSrc,
  output logic [Data_Width-1:0]    ImmOp,
  output logic                     ALU_ctrl,
  output logic [Data_Width-1:0]    pc,
  output logic                     illegal,
  output logic [31:0]              retired
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC} state_t;

  state_t                   state_q, state_d;
  logic [Address_Width-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic                     alusrc_q, alusrc_d, aluctrl_q, aluctrl_d;
  logic [Data_Width-1:0]    imm_q, imm_d, pc_q, pc_d;
  logic                     wr_q, wr_d, bne_q, bne_d, ill_q, ill_d, illegal_q, illegal_d;
  logic [31:0]              retired_q, retired_d;

  // Combinational decode of the word on the bus; latched on the handshake edge
  logic [Address_Width-1:0] dec_rs1, dec_rs2, dec_rd;
  logic                     dec_alusrc, dec_aluctrl, dec_wr, dec_bne, dec_ill;
  logic [Data_Width-1:0]    dec_imm;
  logic [6:0]               opcode, f7;
  logic [2:0]               f3;

  always_comb begin
    opcode      = instr[6:0];
    f3          = instr[14:12];
    f7          = instr[31:25];
    dec_rs1     = '0;
    dec_rs2     = '0;
    dec_rd      = '0;
    dec_alusrc  = 1'b0;
    dec_aluctrl = 1'b0;
    dec_imm     = '0;
    dec_wr      = 1'b0;
    dec_bne     = 1'b0;
    dec_ill     = 1'b0;
    if (opcode == 7'b0010011 && f3 == 3'b000) begin
      dec_rs1    = Address_Width'(instr[19:15]);
      dec_rd     = Address_Width'(instr[11:7]);
      dec_alusrc = 1'b1;
      dec_imm    = {{(Data_Width-12){instr[31]}}, instr[31:20]};
      dec_wr     = 1'b1;
    end else if (opcode == 7'b0110011 && f3 == 3'b000 &&
                 (f7 == 7'b0000000 || f7 == 7'b0100000)) begin
      dec_rs1     = Address_Width'(instr[19:15]);
      dec_rs2     = Address_Width'(instr[24:20]);
      dec_rd      = Address_Width'(instr[11:7]);
      dec_aluctrl = f7[5];
      dec_wr      = 1'b1;
    end else if (opcode == 7'b1100011 && f3 == 3'b001) begin
      dec_rs1     = Address_Width'(instr[19:15]);
      dec_rs2     = Address_Width'(instr[24:20]);
      dec_aluctrl = 1'b1;
      dec_imm     = {{(Data_Width-13){instr[31]}}, instr[31], instr[7],
                     instr[30:25], instr[11:8], 1'b0};
      dec_bne     = 1'b1;
    end else begin
      dec_ill = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    alusrc_d  = alusrc_q;
    aluctrl_d = aluctrl_q;
    imm_d     = imm_q;
    wr_d      = wr_q;
    bne_d     = bne_q;
    ill_d     = ill_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: if (instr_valid) begin
        state_d   = DECODE;
        rs1_d     = dec_rs1;
        rs2_d     = dec_rs2;
        rd_d      = dec_rd;
        alusrc_d  = dec_alusrc;
        aluctrl_d = dec_aluctrl;
        imm_d     = dec_imm;
        wr_d      = dec_wr;
        bne_d     = dec_bne;
        ill_d     = dec_ill;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        state_d   = IDLE;
        pc_d      = (bne_q && !eq) ? pc_q + imm_q : pc_q + Data_Width'(4);
        retired_d = retired_q + 32'd1;
        illegal_d = ill_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      alusrc_q  <= 1'b0;
      aluctrl_q <= 1'b0;
      imm_q     <= '0;
      wr_q      <= 1'b0;
      bne_q     <= 1'b0;
      ill_q     <= 1'b0;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      alusrc_q  <= alusrc_d;
      aluctrl_q <= aluctrl_d;
      imm_q     <= imm_d;
      wr_q      <= wr_d;
      bne_q     <= bne_d;
      ill_q     <= ill_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  // Writes to x0 are suppressed here so the register file never sees them
  assign en       = (state_q == EXEC) && wr_q && (rd_q != '0);
  assign rs1      = rs1_q;
  assign rs2      = rs2_q;
  assign rd       = rd_q;
  assign ALUSrc   = alusrc_q;
  assign ALU_ctrl = aluctrl_q;
  assign ImmOp    = imm_q;
  assign pc       = pc_q;
  assign retired  = retired_q;
  assign illegal  = illegal_q;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control sequencer that sits in front of the register-file/ALU datapath. It accepts 32-bit RV32I instruction words over a valid/ready handshake, decodes the reduced instruction set (ADDI, ADD, SUB, BNE), and drives the datapath's register addresses, write enable, operand-select, immediate and ALU-control inputs. It consumes the ALU `eq` flag to resolve branches, and it maintains the program counter and a retired-instruction counter.

## Interface
Parameters:
- `Address_Width`, 5: register address width.
- `Data_Width`, 32: instruction, immediate and PC width.
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  upstream has an instruction word on `instr`.
- `instr`  in  Data_Width  instruction word.
- `instr_ready`  out  1  sequencer accepts a word this cycle.
- `eq`  in  1  ALU equality flag from the datapath.
- `rs1`, `rs2`, `rd`  out  Address_Width  register addresses to the datapath.
- `en`  out  1  register-file write enable.
- `ALUSrc`  out  1  ALU operand 2 select: 1 selects `ImmOp`, 0 selects `rs2` data.
- `ImmOp`  out  Data_Width  sign-extended immediate.
- `ALU_ctrl`  out  1  ALU operation: 0 = add, 1 = subtract.
- `pc`  out  Data_Width  address of the next instruction.
- `illegal`  out  1  one-cycle pulse when an unsupported word is retired.
- `retired`  out  32  count of completed instructions; wraps at 2^32.

## Operation
- FSM states: IDLE, DECODE, EXEC.
  - IDLE -> DECODE on `instr_valid && instr_ready`.
  - DECODE -> EXEC unconditionally.
  - EXEC -> IDLE unconditionally.
- `instr_ready = (state == IDLE)`, combinational. A word is captured into an internal register on the handshake edge.
- Decode happens on the DECODE edge. Field outputs are registered and hold from the first cycle of DECODE through the end of EXEC.
  - ADDI (opcode 0010011, f3 000): `rs1` = instr[19:15], `rd` = instr[11:7], `ALUSrc` = 1, `ALU_ctrl` = 0, `ImmOp` = sext(instr[31:20]).
  - ADD / SUB (opcode 0110011, f3 000, f7 0000000 / 0100000): `rs1`, `rs2`, `rd` from the standard fields, `ALUSrc` = 0, `ALU_ctrl` = 0 for ADD and 1 for SUB, `ImmOp` = 0.
  - BNE (opcode 1100011, f3 001): `rs1`, `rs2` from the fields, `rd` = 0, `ALUSrc` = 0, `ALU_ctrl` = 1, `ImmOp` = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - Any other encoding is illegal. All field outputs are 0.
- `en` is 1 only during EXEC, only for ADDI/ADD/SUB, and only when `rd != 0`. It is 0 in every other cycle.
- On the EXEC -> IDLE edge:
  - `pc` <= `pc + ImmOp` for BNE with `eq` = 0. Otherwise `pc` <= `pc + 4`. Arithmetic is modulo 2^Data_Width.
  - `retired` increments by 1, including for illegal words.
  - `illegal` is 1 for the IDLE cycle that follows an illegal word. It is 0 otherwise.
- `eq` is sampled only in the EXEC cycle. It is ignored in all other cycles.
- Reset while `rst` is high, at the next edge:
  - State = IDLE.
  - `pc` = RESET_PC.
  - `retired` = 0.
  - All field outputs, `en` and `illegal` = 0.
  - Any in-flight instruction is discarded with no write and no PC update.
  - A handshake in a cycle with `rst` high is not accepted.

## Timing
- Latency: handshake edge T, DECODE in cycle T+1, EXEC (write) in T+2. `pc` and `retired` update at the end of T+2.
- `instr_ready` is high again in T+3. Peak throughput is one instruction per 3 cycles.
- Back-to-back: a word held valid during IDLE is accepted in the first IDLE cycle.
- `instr_ready` is high in the first cycle after `rst` deasserts.

## Test plan
- Reset: hold `rst` 2 cycles -> `pc` = 0, `retired` = 0, `en` = 0, `instr_ready` = 1 in the first post-reset cycle.
- ADDI x1,x0,5 (0x00500093):
  - DECODE: `rs1` = 0, `rd` = 1, `ALUSrc` = 1, `ImmOp` = 5, `ALU_ctrl` = 0.
  - EXEC: `en` = 1.
  - Then `pc` 0 -> 4, `retired` = 1.
- ADD x3,x1,x2 (0x002081B3) -> `rs1` = 1, `rs2` = 2, `rd` = 3, `ALUSrc` = 0, `ALU_ctrl` = 0, `en` = 1 in EXEC only.
- BNE x1,x0,-4 (0xFE009EE3) at `pc` = 4:
  - DECODE: `ImmOp` = 0xFFFFFFFC, `ALU_ctrl` = 1.
  - With `eq` = 0 in EXEC -> `pc` = 0.
  - Repeated with `eq` = 1 -> `pc` = 8.
  - `en` = 0 throughout both runs.
- Edge cases:
  - ADDI x0,x0,1 (0x00100013) -> `en` stays 0, `pc` + 4.
  - Word 0x00000000 -> `illegal` pulses 1 cycle, `en` = 0, `pc` + 4, `retired` + 1.
- Assert `rst` during EXEC of an ADDI -> no `en` pulse after the reset edge, `pc` = 0, `retired` = 0, state IDLE.
